// File: rtl/fcvt_fp_seq.sv
// fcvt_fp_seq: sequential int64/uint64 -> IEEE-754 double converter, round to nearest-even.
// FCVT_FAST_NORM_EN: normalize 8 bits per cycle while the top byte of the magnitude is zero.
module fcvt_fp_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in,
    input  logic        is_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] fp,
    output logic        inexact
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t state, state_nx;
    logic [63:0] mag, mag_nx;
    logic [6:0] cnt, cnt_nx;
    logic sign, accept, round_up, ovf;
    logic [51:0] mant;
    logic [10:0] exp;
    assign in_ready = (state == IDLE) & rst_n;
    assign accept = in_valid & in_ready;
    always_comb begin
        state_nx = state;
        mag_nx = mag;
        cnt_nx = cnt;
        case (state)
            IDLE: if (accept) begin
                mag_nx = (in[63] & ~is_unsigned) ? -in : in;
                cnt_nx = 7'd0;
                state_nx = (mag_nx == 64'd0) ? ROUND : NORM;
            end
            NORM: if (mag[63]) state_nx = ROUND;
`ifdef FCVT_FAST_NORM_EN
            else if (mag[63:56] == 8'd0) begin
                mag_nx = mag << 8;
                cnt_nx = cnt + 7'd8;
            end
`endif
            else begin
                mag_nx = mag << 1;
                cnt_nx = cnt + 7'd1;
            end
            ROUND: state_nx = DONE;
            DONE: state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // An unnormalized magnitude in ROUND can only be zero, which encodes as +0.0.
    always_comb begin
        round_up = mag[10] & ((|mag[9:0]) | mag[11]);
        {ovf, mant} = {1'b0, mag[62:11]} + {52'd0, round_up};
        exp = 11'd1086 - {4'd0, cnt} + {10'd0, ovf};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mag <= 64'd0;
            cnt <= 7'd0;
            sign <= 1'b0;
            out_valid <= 1'b0;
            fp <= 64'd0;
            inexact <= 1'b0;
        end else begin
            state <= state_nx;
            mag <= mag_nx;
            cnt <= cnt_nx;
            if (accept) sign <= in[63] & ~is_unsigned;
            if (state == ROUND) begin
                out_valid <= 1'b1;
                fp <= mag[63] ? {sign, exp, mant} : 64'd0;
                inexact <= mag[63] & (mag[10] | (|mag[9:0]));
            end else if (state == DONE && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fcvt_fp_seq.sv
// tb_fcvt_fp_seq: directed self-checking bench for fcvt_fp_seq.
// Expected latencies follow FCVT_FAST_NORM_EN when the bench is built with it.
module tb_fcvt_fp_seq;
    logic clk = 0, rst_n = 0, in_valid = 0, is_unsigned = 0, out_ready = 0;
    logic [63:0] in = 64'd0;
    logic in_ready, out_valid, inexact;
    logic [63:0] fp;
    int checks = 0, failures = 0;
    logic [63:0] tv_in [7] = '{64'd1, 64'hFFFFFFFFFFFFFFF6, 64'd1000000000000, 64'h0020000000000001,
                               64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    logic tv_u [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [63:0] tv_fp [7] = '{64'h3FF0000000000000, 64'hC024000000000000, 64'h426D1A94A2000000,
                               64'h4340000000000000, 64'hC3E0000000000000, 64'h43F0000000000000,
                               64'hBFF0000000000000};
    logic tv_ix [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int tv_lz [7] = '{63, 60, 24, 10, 0, 0, 63};

    always #5 clk = ~clk;

    fcvt_fp_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .is_unsigned(is_unsigned), .out_valid(out_valid), .out_ready(out_ready),
        .fp(fp), .inexact(inexact)
    );

    function automatic int lat_of(input int lz);
`ifdef FCVT_FAST_NORM_EN
        return lz / 8 + lz % 8 + 2;
`else
        return lz + 2;
`endif
    endfunction

    task automatic run(input logic [63:0] v, input logic u, output int lat);
        @(negedge clk);
        in = v;
        is_unsigned = u;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 100);
    endtask

    task automatic drain;
        @(negedge clk);
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (fp !== 64'd0) begin failures++; $display("FAIL reset_fp got=%h exp=0", fp); end
        checks++; if (inexact !== 1'b0) begin failures++; $display("FAIL reset_inexact got=%b exp=0", inexact); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_zero_stall;
        int lat;
        run(64'd0, 1'b0, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        checks++; if (fp !== 64'd0) begin failures++; $display("FAIL zero_fp got=%h exp=0", fp); end
        checks++; if (inexact !== 1'b0) begin failures++; $display("FAIL zero_inexact got=%b exp=0", inexact); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in = 64'd5;
            in_valid = (i == 2);
            checks++; if (fp !== 64'd0) begin failures++; $display("FAIL stall_fp[%0d] got=%h exp=0", i, fp); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
        end
        @(negedge clk);
        in_valid = 0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pre_release_in_ready got=%b exp=0", in_ready); end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL no_capture_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_conversions;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run(tv_in[i], tv_u[i], lat);
            checks++; if (fp !== tv_fp[i]) begin failures++; $display("FAIL conv_fp[%0d] got=%h exp=%h", i, fp, tv_fp[i]); end
            checks++; if (inexact !== tv_ix[i]) begin failures++; $display("FAIL conv_inexact[%0d] got=%b exp=%b", i, inexact, tv_ix[i]); end
            checks++; if (lat !== lat_of(tv_lz[i])) begin failures++; $display("FAIL conv_latency[%0d] got=%0d exp=%0d", i, lat, lat_of(tv_lz[i])); end
            drain();
        end
    endtask

    task automatic test_reset_mid_norm;
        int lat;
        @(negedge clk);
        in = 64'd1;
        is_unsigned = 0;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (20) @(posedge clk);
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
        checks++; if (fp !== 64'd0) begin failures++; $display("FAIL midreset_fp got=%h exp=0", fp); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL after_reset_in_ready got=%b exp=1", in_ready); end
        run(64'd2, 1'b0, lat);
        checks++; if (fp !== 64'h4000000000000000) begin failures++; $display("FAIL after_reset_fp got=%h exp=4000000000000000", fp); end
        checks++; if (inexact !== 1'b0) begin failures++; $display("FAIL after_reset_inexact got=%b exp=0", inexact); end
        checks++; if (lat !== lat_of(62)) begin failures++; $display("FAIL after_reset_latency got=%0d exp=%0d", lat, lat_of(62)); end
        drain();
    endtask

    initial begin
        test_reset();
        test_zero_stall();
        test_conversions();
        test_reset_mid_norm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
